// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encodings and counter-width helper shared by the bit-serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// serial_subtractor_fullsubtractor: 1-bit borrow cell, ports A,B,Bin in; D,Bout out
module serial_subtractor_fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial Diff=A-B-Bin; ports CLK,RST,Start,A,B,Bin in; Ready,Busy,Done,Diff,Bout (+Ovf with SERIAL_SUB_OVF_EN) out
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             Bout
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sha, r_shb, r_diff;
  logic [WIDTH-2:0] r_shd;
  logic [WIDTH-1:0] w_shd;
  logic [CW-1:0]    r_cnt;
  logic             r_brw, r_bout, w_d, w_bo, w_accept, w_last;
  serial_subtractor_fullsubtractor u_fs (
    .A(r_sha[0]), .B(r_shb[0]), .Bin(r_brw), .D(w_d), .Bout(w_bo)
  );
  assign w_accept = Start & (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));
  // partial difference with the current bit placed at the MSB
  assign w_shd    = {w_d, r_shd};
  always_comb begin
    w_next = w_accept ? ST_RUN : (r_state == ST_RUN) ? (w_last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  assign Ready = (r_state != ST_RUN);
  assign Busy  = (r_state == ST_RUN);
  assign Done  = (r_state == ST_DONE);
  assign Diff  = r_diff;
  assign Bout  = r_bout;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_shd   <= '0;
      r_cnt   <= '0;
      r_brw   <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sha <= A;
        r_shb <= B;
        r_brw <= Bin;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_sha <= {1'b0, r_sha[WIDTH-1:1]};
        r_shb <= {1'b0, r_shb[WIDTH-1:1]};
        r_shd <= w_shd[WIDTH-1:1];
        r_brw <= w_bo;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_shd;
          r_bout <= w_bo;
        end
      end
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic r_amsb, r_bmsb, r_ovf;
  assign Ovf = r_ovf;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_amsb <= A[WIDTH-1];
        r_bmsb <= B[WIDTH-1];
      end
      if (w_last) r_ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
    end
  end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the 4-bit bit-serial subtractor
module tb_serial_subtractor;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       Bin = 1'b0;
  logic       Ready, Busy, Done, Bout;
  logic [3:0] Diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       Ovf;
`endif
  int errs = 0;
  int checks = 0;
  serial_subtractor #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Diff(Diff),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf(Ovf),
`endif
    .Bout(Bout)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bin);
    A = a;
    B = b;
    Bin = bin;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int n0);
    int n = n0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
  endtask
  initial begin
    tick();
    tick();
    RST = 1'b0;
    chk("rst_ready", Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    start_op(4'd7, 4'd3, 1'b0);
    chk("t1_busy", Busy, 1);
    chk("t1_ready", Ready, 0);
    wait_done("t1", 0);
    chk("t1_diff", Diff, 4);
    chk("t1_bout", Bout, 0);
    chk("t1_ready_done", Ready, 1);
    tick();
    chk("t1_idle_done", Done, 0);
    start_op(4'd3, 4'd7, 1'b0);
    wait_done("t2", 0);
    chk("t2_diff", Diff, 12);
    chk("t2_bout", Bout, 1);
    tick();
    start_op(4'd0, 4'd0, 1'b1);
    wait_done("t3", 0);
    chk("t3_diff", Diff, 15);
    chk("t3_bout", Bout, 1);
    start_op(4'd15, 4'd15, 1'b0);
    chk("t3b_b2b_busy", Busy, 1);
    chk("t3b_diff_held", Diff, 15);
    wait_done("t3b", 0);
    chk("t3b_diff", Diff, 0);
    chk("t3b_bout", Bout, 0);
    tick();
    start_op(4'd9, 4'd2, 1'b0);
    tick();
    A = 4'd1;
    B = 4'd1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done("t4", 2);
    chk("t4_diff", Diff, 7);
    chk("t4_bout", Bout, 0);
    tick();
    chk("t4_no_rerun", Busy, 0);
    start_op(4'd5, 4'd1, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_ready", Ready, 1);
    chk("t5_busy", Busy, 0);
    chk("t5_diff", Diff, 0);
    chk("t5_bout", Bout, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_done", Done, 0);
      tick();
    end
`ifdef SERIAL_SUB_OVF_EN
    start_op(4'b0111, 4'b1111, 1'b0);
    wait_done("t6a", 0);
    chk("t6a_diff", Diff, 8);
    chk("t6a_ovf", Ovf, 1);
    tick();
    start_op(4'd5, 4'd2, 1'b0);
    wait_done("t6b", 0);
    chk("t6b_diff", Diff, 3);
    chk("t6b_ovf", Ovf, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
